sprite_blit: RTL
================

SPRITE_BLIT -- requirements
Module: sprite_blit

Interface
REQ-001 SHALL have parameter SCREEN_START, default 'h100: base address of the frame buffer.
REQ-002 SHALL have parameter SCREEN_W, default 64: screen width in pixels, a multiple of 8, at most 128.
REQ-003 SHALL have parameter SCREEN_H, default 32: screen height in pixels, at most 64.
REQ-004 SHALL have parameter WRAP, default 0: 0 means off-screen pixels are clipped, 1 means they wrap modulo width/height.
REQ-005 SHALL have one clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; reset in 1, async active-high reset.
REQ-006 SHALL have ports:
- draw in 1: start sprite draw
- clear in 1: start screen clear
- wide in 1: 16x16 sprite mode
- addr in 16: sprite address
- lines in 4: row count
- x in 8, y in 8: pixel coordinates
- ready out 1: idle
- collision out 1: a set pixel was erased
REQ-007 SHALL have memory ports:
- mem_read out 1, mem_write out 1
- mem_addr out 16, mem_write_byte out 8
- mem_read_byte in 8: valid in the cycle after a mem_read-high cycle

Function
REQ-008 SHALL use states IDLE, FETCH, LOAD, STORE, NEXT_ROW and CLEAR; ready SHALL be high only in IDLE.
REQ-009 SHALL pulse mem_read/mem_write for one cycle per access, and hold mem_read, mem_write, mem_addr and mem_write_byte at 0 in cycles with no access.
REQ-010 SHALL ignore draw/clear when not ready; if both are high in IDLE, clear wins and draw is dropped.
REQ-011 SHALL, on an accepted draw, clear collision and latch x mod SCREEN_W, y mod SCREEN_H, addr, wide and row count.
- Row count: lines if nonzero.
- lines=0 with wide=1: 16 rows.
- lines=0 with wide=0: draw completes with no memory access; ready returns the next cycle.
REQ-012 SHALL, per sprite row, fetch 1 byte (wide=0) or 2 consecutive bytes, MSB byte first (wide=1), from sequential sprite addresses; each fetch takes 2 cycles (read, capture).
REQ-013 SHALL shift the row right by x mod 8 and touch ceil((spritewidth + x mod 8)/8) screen bytes, left to right; with x mod 8 = 0 that is exactly 1 byte (narrow) or 2 bytes (wide).
REQ-014 SHALL access each screen byte in 2 cycles.
- Cycle 1: mem_read at that byte's address.
- Cycle 2: mem_write of read XOR sprite bits, to the same address.
REQ-015 SHALL compute screen byte address as SCREEN_START + row*(SCREEN_W/8) + column, in 16-bit arithmetic.
REQ-016 SHALL, when WRAP=0, skip (no read, no write) any byte whose column is at or beyond SCREEN_W/8, and end the draw at the first row at or beyond SCREEN_H.
REQ-017 SHALL, when WRAP=1, take column modulo SCREEN_W/8 and row modulo SCREEN_H.
REQ-018 SHALL set collision if any written byte has a bit that was 1 and is cleared by the XOR; collision is sticky until the next accepted draw/clear and valid when ready rises.
REQ-019 SHALL, in NEXT_ROW, decrement the row count and return to FETCH, or to IDLE when it reaches zero.
REQ-020 SHALL, on clear, write 0x00 to SCREEN_START through SCREEN_START + SCREEN_W*SCREEN_H/8 - 1, one write per cycle in ascending order, without reads, clear collision, then return to IDLE.

Reset
REQ-021 SHALL, on reset (any time, including mid-draw/clear), immediately force state IDLE, ready 1, collision 0, all memory outputs 0, and internal counters/addresses 0; the aborted operation SHALL NOT resume.

Verification (defaults, zeroed memory)
REQ-022 Draw x=0, y=0, lines=1, sprite 0xFF -> exactly one write, 0x100=0xFF, collision 0, ready high 4 cycles after acceptance.
REQ-023 Repeat REQ-022 -> 0x100=0x00, collision 1.
REQ-024 x=60, y=0, sprite 0xFF, WRAP=0 -> 0x107=0x0F, no access to 0x108; WRAP=1 -> also 0x100=0xF0.
REQ-025 wide=1, lines=0, y=24, WRAP=0 -> 16 sprite bytes fetched for rows 24..31 only, then ready; WRAP=1 -> 32 bytes fetched, rows 0..7 also written.
REQ-026 clear -> 256 writes of 0x00 to 0x100..0x1FF, ready low for 256 cycles; draw held high in the same cycle is ignored.
REQ-027 Reset asserted mid-draw after one write -> outputs at reset values in the same cycle, no further writes, ready 1.

Source files
------------

// File: rtl/sprite_blit.sv
// sprite_blit: XOR sprite blitter and screen clearer for a 1-bpp frame buffer.
// Sprite rows (8 or 16 pixels) are fetched from memory, shifted to the pixel
// x position and XORed into the screen with read/write pairs; a clear fills
// the frame buffer with zero bytes. Erasing a set pixel raises collision_o.
module sprite_blit #(
    parameter logic [15:0] SCREEN_START = 16'h0100,
    parameter int          SCREEN_W     = 64,
    parameter int          SCREEN_H     = 32,
    parameter int          WRAP         = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        draw_i,
    input  logic        clear_i,
    input  logic        wide_i,
    input  logic [15:0] addr_i,
    input  logic [3:0]  lines_i,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    output logic        ready_o,
    output logic        collision_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_write_byte_o,
    input  logic [7:0]  mem_read_byte_i
);

    localparam int          COLS     = SCREEN_W / 8;
    localparam logic [7:0]  COLS_L   = 8'(COLS);
    localparam logic [7:0]  ROWS_L   = 8'(SCREEN_H);
    localparam logic [15:0] CLR_LAST = 16'((SCREEN_W * SCREEN_H / 8) - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        STORE    = 3'd3,
        NEXT_ROW = 3'd4,
        CLEAR    = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] addr_q;       // next sprite byte address
    logic        wide_q;
    logic        first_q;      // first of the two fetches of a wide row pending
    logic [4:0]  rows_q;       // rows still to draw
    logic [7:0]  row_q;        // current screen row
    logic [7:0]  col0_q;       // column of the leftmost touched byte
    logic [7:0]  col_q;        // column of the byte being accessed
    logic [2:0]  shift_q;      // x mod 8
    logic [1:0]  byte_idx_q;   // index of the byte within the shifted row
    logic [15:0] sprite_q;     // fetched row; narrow rows live in [7:0]
    logic [15:0] clr_cnt_q;
    logic        collision_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [15:0] mem_addr_q;

    logic [23:0] pat_d;
    logic [7:0]  byte_d;
    logic [1:0]  last_idx_d;
    logic        last_byte_d;
    logic [7:0]  ncol_d;
    logic        ncol_ok_d;
    logic [7:0]  nrow_d;
    logic        nrow_ok_d;
    logic [4:0]  rows_init_d;
    logic [7:0]  xm_d;
    logic [7:0]  ym_d;

    // Screen byte address for a row/column pair, 16-bit wrap-around arithmetic.
    function automatic logic [15:0] scr_addr(input logic [7:0] row, input logic [7:0] col);
        scr_addr = SCREEN_START + (16'(row) * 16'(COLS)) + 16'(col);
    endfunction

    // Shifted sprite row and the screen byte selected by byte_idx_q.
    always_comb begin
        if (wide_q) begin
            pat_d      = {sprite_q, 8'h00} >> shift_q;
            last_idx_d = (shift_q != 3'd0) ? 2'd2 : 2'd1;
        end else begin
            pat_d      = {sprite_q[7:0], 16'h0000} >> shift_q;
            last_idx_d = (shift_q != 3'd0) ? 2'd1 : 2'd0;
        end
        case (byte_idx_q)
            2'd0:    byte_d = pat_d[23:16];
            2'd1:    byte_d = pat_d[15:8];
            2'd2:    byte_d = pat_d[7:0];
            default: byte_d = 8'h00;
        endcase
        last_byte_d = (byte_idx_q == last_idx_d);
    end

    // Next column / next row with clipping or wrap-around.
    always_comb begin
        if (WRAP != 0) begin
            ncol_d    = (col_q == (COLS_L - 8'd1)) ? 8'd0 : (col_q + 8'd1);
            ncol_ok_d = 1'b1;
            nrow_d    = (row_q == (ROWS_L - 8'd1)) ? 8'd0 : (row_q + 8'd1);
            nrow_ok_d = 1'b1;
        end else begin
            ncol_d    = col_q + 8'd1;
            ncol_ok_d = (ncol_d < COLS_L);
            nrow_d    = row_q + 8'd1;
            nrow_ok_d = (nrow_d < ROWS_L);
        end
    end

    // Values latched when a draw is accepted.
    always_comb begin
        xm_d = 8'(32'(x_i) % SCREEN_W);
        ym_d = 8'(32'(y_i) % SCREEN_H);
        if (lines_i != 4'd0) begin
            rows_init_d = {1'b0, lines_i};
        end else if (wide_i) begin
            rows_init_d = 5'd16;
        end else begin
            rows_init_d = 5'd0;
        end
    end

    // Write data is the screen byte just read XOR the sprite bits; zero otherwise.
    always_comb begin
        if (mem_write_q && (state_q == STORE)) begin
            mem_write_byte_o = mem_read_byte_i ^ byte_d;
        end else begin
            mem_write_byte_o = 8'h00;
        end
    end

    // Control FSM; memory strobes and address are registered and default to zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            addr_q      <= 16'h0000;
            wide_q      <= 1'b0;
            first_q     <= 1'b0;
            rows_q      <= 5'd0;
            row_q       <= 8'd0;
            col0_q      <= 8'd0;
            col_q       <= 8'd0;
            shift_q     <= 3'd0;
            byte_idx_q  <= 2'd0;
            sprite_q    <= 16'h0000;
            clr_cnt_q   <= 16'h0000;
            collision_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 16'h0000;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 16'h0000;
            case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        state_q     <= CLEAR;
                        collision_q <= 1'b0;
                        clr_cnt_q   <= 16'h0000;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= SCREEN_START;
                    end else if (draw_i) begin
                        collision_q <= 1'b0;
                        addr_q      <= addr_i;
                        wide_q      <= wide_i;
                        first_q     <= 1'b1;
                        rows_q      <= rows_init_d;
                        row_q       <= ym_d;
                        col0_q      <= {3'b000, xm_d[7:3]};
                        col_q       <= {3'b000, xm_d[7:3]};
                        shift_q     <= x_i[2:0];
                        byte_idx_q  <= 2'd0;
                        if (rows_init_d == 5'd0) begin
                            state_q <= NEXT_ROW;
                        end else begin
                            state_q    <= FETCH;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= addr_i;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FETCH: begin
                    // The capture cycle of the last fetch also reads the first screen byte.
                    state_q <= LOAD;
                    addr_q  <= addr_q + 16'd1;
                    if (!wide_q || !first_q) begin
                        mem_read_q <= 1'b1;
                        mem_addr_q <= scr_addr(row_q, col0_q);
                        col_q      <= col0_q;
                        byte_idx_q <= 2'd0;
                    end else begin
                        mem_read_q <= 1'b0;
                    end
                end
                LOAD: begin
                    sprite_q <= {sprite_q[7:0], mem_read_byte_i};
                    if (wide_q && first_q) begin
                        first_q    <= 1'b0;
                        state_q    <= FETCH;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= addr_q;
                    end else begin
                        state_q     <= STORE;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= mem_addr_q;
                    end
                end
                STORE: begin
                    if (mem_write_q) begin
                        if ((mem_read_byte_i & byte_d) != 8'h00) begin
                            collision_q <= 1'b1;
                        end else begin
                            collision_q <= collision_q;
                        end
                        if (!last_byte_d && ncol_ok_d) begin
                            col_q      <= ncol_d;
                            byte_idx_q <= byte_idx_q + 2'd1;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= scr_addr(row_q, ncol_d);
                        end else begin
                            state_q <= NEXT_ROW;
                        end
                    end else begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= mem_addr_q;
                    end
                end
                NEXT_ROW: begin
                    if ((rows_q <= 5'd1) || !nrow_ok_d) begin
                        rows_q  <= 5'd0;
                        state_q <= IDLE;
                    end else begin
                        rows_q     <= rows_q - 5'd1;
                        row_q      <= nrow_d;
                        first_q    <= 1'b1;
                        state_q    <= FETCH;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= addr_q;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        clr_cnt_q <= 16'h0000;
                        state_q   <= IDLE;
                    end else begin
                        clr_cnt_q   <= clr_cnt_q + 16'd1;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= SCREEN_START + clr_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign collision_o = collision_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;

endmodule
